// File: rtl/ddr2_aref_if.sv
// Command-bus and handshake bundle between the auto-refresh engine and the controller arbiter.
interface ddr2_aref_if #(
    parameter int unsigned BA_BITS   = 3,
    parameter int unsigned ADDR_BITS = 13
);
    logic                 init_end;
    logic                 aref_en;
    logic                 aref_req;
    logic                 aref_urgent;
    logic                 aref_busy;
    logic [3:0]           aref_cmd;
    logic [BA_BITS-1:0]   aref_ba;
    logic [ADDR_BITS-1:0] aref_addr;
    logic                 aref_end;
    logic                 aref_overflow;

    modport master (
        input  init_end, aref_en,
        output aref_req, aref_urgent, aref_busy, aref_cmd, aref_ba, aref_addr,
        output aref_end, aref_overflow
    );

    modport slave (
        output init_end, aref_en,
        input  aref_req, aref_urgent, aref_busy, aref_cmd, aref_ba, aref_addr,
        input  aref_end, aref_overflow
    );
endinterface

// File: rtl/ddr2_aref.sv
// DDR2 periodic auto-refresh engine: times tREFI, tracks postponed refreshes and, once granted,
// issues PRECHARGE-ALL, waits tRP, issues AUTO REFRESH, waits tRFC and pulses aref_end.
module ddr2_aref #(
    parameter int unsigned BA_BITS   = 3,
    parameter int unsigned ADDR_BITS = 13,
    parameter int unsigned tCK       = 5,
    parameter int unsigned tREFI     = 7800,
    parameter int unsigned tRP       = 20,
    parameter int unsigned tRFC      = 130,
    parameter int unsigned MAX_PEND  = 8,
    parameter int unsigned URGENT_TH = 6
) (
    input  logic        clk,
    input  logic        rst,
    ddr2_aref_if.master bus
);
    localparam int unsigned REFI_CYC = (tREFI + tCK - 1) / tCK;
    localparam int unsigned RP_CYC   = (tRP + tCK - 1) / tCK;
    localparam int unsigned RFC_CYC  = (tRFC + tCK - 1) / tCK;
    localparam int unsigned MAX_WAIT = (RFC_CYC > RP_CYC) ? RFC_CYC : RP_CYC;
    localparam int unsigned RefiW    = $clog2(REFI_CYC);
    localparam int unsigned PendW    = $clog2(MAX_PEND + 1);
    localparam int unsigned WaitW    = $clog2(MAX_WAIT);

    localparam logic [3:0] CmdNop  = 4'b0111;
    localparam logic [3:0] CmdPre  = 4'b0010;
    localparam logic [3:0] CmdAref = 4'b0001;

    typedef enum logic [2:0] {StIdle, StPre, StWaitRp, StAref, StWaitRfc} state_e;

    state_e             state_q, state_d;
    logic [WaitW-1:0]   wait_q, wait_d;
    logic [RefiW-1:0]   refi_q, refi_d;
    logic [PendW-1:0]   pend_q, pend_d;
    logic [3:0]         cmd_q, cmd_d;
    logic               addr10_q, addr10_d;
    logic               end_q, end_d;
    logic               ovf_q, ovf_d;
    logic               tick, done, req;

    assign req  = (state_q == StIdle) && (pend_q != '0);
    assign tick = bus.init_end && (refi_q == RefiW'(REFI_CYC - 1));

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        done    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req && bus.aref_en) state_d = StPre;
            end
            StPre: begin
                wait_d = '0;
                if (RP_CYC > 1) state_d = StWaitRp;
                else            state_d = StAref;
            end
            StWaitRp: begin
                if (wait_q == WaitW'(RP_CYC - 2)) state_d = StAref;
                else                              wait_d  = wait_q + WaitW'(1);
            end
            StAref: begin
                wait_d  = '0;
                state_d = StWaitRfc;
            end
            StWaitRfc: begin
                if (wait_q == WaitW'(RFC_CYC - 2)) begin
                    state_d = StIdle;
                    done    = 1'b1;
                end else begin
                    wait_d = wait_q + WaitW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
        if (!bus.init_end) begin
            state_d = StIdle;
            done    = 1'b0;
        end
    end

    always_comb begin
        refi_d = (!bus.init_end || tick) ? '0 : refi_q + RefiW'(1);
        pend_d = pend_q;
        ovf_d  = ovf_q;
        if (!bus.init_end) begin
            pend_d = '0;
        end else if (tick && !done) begin
            if (pend_q == PendW'(MAX_PEND)) ovf_d  = 1'b1;
            else                            pend_d = pend_q + PendW'(1);
        end else if (done && !tick) begin
            pend_d = pend_q - PendW'(1);
        end
        // A tick coinciding with completion is absorbed by the retiring refresh, never lost.
    end

    always_comb begin
        cmd_d    = CmdNop;
        addr10_d = 1'b0;
        end_d    = done;
        if (state_d == StPre) begin
            cmd_d    = CmdPre;
            addr10_d = 1'b1;
        end else if (state_d == StAref) begin
            cmd_d = CmdAref;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            wait_q   <= '0;
            refi_q   <= '0;
            pend_q   <= '0;
            cmd_q    <= CmdNop;
            addr10_q <= 1'b0;
            end_q    <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wait_q   <= wait_d;
            refi_q   <= refi_d;
            pend_q   <= pend_d;
            cmd_q    <= cmd_d;
            addr10_q <= addr10_d;
            end_q    <= end_d;
            ovf_q    <= ovf_d;
        end
    end

    assign bus.aref_req      = req;
    assign bus.aref_urgent   = pend_q >= PendW'(URGENT_TH);
    assign bus.aref_busy     = state_q != StIdle;
    assign bus.aref_cmd      = cmd_q;
    assign bus.aref_ba       = '0;
    assign bus.aref_end      = end_q;
    assign bus.aref_overflow = ovf_q;

    always_comb begin
        bus.aref_addr     = '0;
        bus.aref_addr[10] = addr10_q;
    end
endmodule

// File: tb/tb_ddr2_aref.sv
// Scoreboard bench for ddr2_aref with tREFI=400 (REFI_CYC=80, RP_CYC=4, RFC_CYC=26).
module tb_ddr2_aref;
    localparam int REFI = 80;
    localparam int RP   = 4;
    localparam int RFC  = 26;
    localparam int SEQ  = 1 + RP + RFC;
    localparam int EvPre = 1, EvAref = 2, EvEnd = 3;

    typedef struct {
        int kind;
        int at;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    ev_t  exp_q[$];

    ddr2_aref_if #(.BA_BITS(3), .ADDR_BITS(13)) bif ();

    ddr2_aref #(
        .BA_BITS  (3),
        .ADDR_BITS(13),
        .tCK      (5),
        .tREFI    (400),
        .tRP      (20),
        .tRFC     (130),
        .MAX_PEND (8),
        .URGENT_TH(6)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bif)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_ev(input int kind, input int at);
        ev_t e;
        e.kind = kind;
        e.at   = at;
        exp_q.push_back(e);
    endtask

    // g is the cycle in which PRE is expected on the bus.
    task automatic push_seq(input int g);
        push_ev(EvPre, g);
        push_ev(EvAref, g + RP);
        push_ev(EvEnd, g + SEQ - 1);
    endtask

    task automatic to_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    always @(negedge clk) begin : monitor
        int   kind;
        ev_t  e;
        logic [12:0] want_addr;
        kind = 0;
        if (bif.aref_cmd == 4'b0010) kind = EvPre;
        else if (bif.aref_cmd == 4'b0001) kind = EvAref;
        else if (bif.aref_end === 1'b1) kind = EvEnd;
        else if (bif.aref_cmd !== 4'b0111) begin
            checks++;
            errors++;
            $display("FAIL bus_cmd: got %b expected 0111 (cycle %0d)", bif.aref_cmd, cyc);
        end
        if (kind != 0) begin
            checks++;
            want_addr = (kind == EvPre) ? 13'h400 : 13'h000;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL bus_event: got unexpected kind %0d at cycle %0d, expected none",
                         kind, cyc);
            end else begin
                e = exp_q.pop_front();
                if (e.kind != kind || e.at != cyc || bif.aref_addr !== want_addr ||
                    bif.aref_ba !== 3'd0) begin
                    errors++;
                    $display("FAIL bus_event: got kind %0d cycle %0d addr %0h ba %0h, expected kind %0d cycle %0d addr %0h ba 0",
                             kind, cyc, bif.aref_addr, bif.aref_ba, e.kind, e.at, want_addr);
                end
            end
        end
    end

    initial begin : stim
        int   c0;
        logic bad;
        bif.init_end = 1'b0;
        bif.aref_en  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_cmd", 32'(bif.aref_cmd), 32'h7);
        chk("rst_ba", 32'(bif.aref_ba), 32'h0);
        chk("rst_addr", 32'(bif.aref_addr), 32'h0);
        chk("rst_req", 32'(bif.aref_req), 32'h0);
        chk("rst_urgent", 32'(bif.aref_urgent), 32'h0);
        chk("rst_busy", 32'(bif.aref_busy), 32'h0);
        chk("rst_end", 32'(bif.aref_end), 32'h0);
        chk("rst_ovf", 32'(bif.aref_overflow), 32'h0);
        rst = 1'b0;

        // Pre-init: nothing may happen while init_end is low.
        bad = 1'b0;
        bif.aref_en = 1'b1;
        repeat (3000) begin
            @(negedge clk);
            if (bif.aref_req !== 1'b0 || bif.aref_cmd !== 4'b0111 || bif.aref_end !== 1'b0)
                bad = 1'b1;
        end
        chk("preinit_quiet", 32'(bad), 32'h0);

        // Basic periodic refresh with the grant tied high.
        c0 = cyc;
        bif.init_end = 1'b1;
        push_seq(c0 + REFI + 1);
        push_seq(c0 + 2 * REFI + 1);
        to_cyc(c0 + REFI - 1);
        chk("basic_req_before_tick", 32'(bif.aref_req), 32'h0);
        to_cyc(c0 + REFI);
        chk("basic_req_at_tick", 32'(bif.aref_req), 32'h1);
        to_cyc(c0 + REFI + 2);
        chk("basic_busy", 32'(bif.aref_busy), 32'h1);
        to_cyc(c0 + 200);
        chk("basic_drain", 32'(exp_q.size()), 32'h0);
        bif.init_end = 1'b0;
        repeat (3) @(negedge clk);

        // Postponement: six ticks without a grant, then release.
        bif.aref_en = 1'b0;
        c0 = cyc;
        bif.init_end = 1'b1;
        to_cyc(c0 + 5 * REFI - 1);
        chk("post_urgent_at5", 32'(bif.aref_urgent), 32'h0);
        to_cyc(c0 + 6 * REFI);
        chk("post_urgent_at6", 32'(bif.aref_urgent), 32'h1);
        chk("post_req", 32'(bif.aref_req), 32'h1);
        chk("post_idle", 32'(bif.aref_busy), 32'h0);
        bif.aref_en = 1'b1;
        for (int i = 0; i < 6; i++) push_seq(c0 + 6 * REFI + 1 + SEQ * i);
        to_cyc(c0 + 6 * REFI + SEQ - 1);
        chk("post_urgent_before_end", 32'(bif.aref_urgent), 32'h1);
        to_cyc(c0 + 6 * REFI + SEQ);
        chk("post_urgent_after_end", 32'(bif.aref_urgent), 32'h0);
        to_cyc(c0 + 640);
        bif.aref_en = 1'b0;
        to_cyc(c0 + 667);
        chk("post_req_left", 32'(bif.aref_req), 32'h1);
        chk("post_busy_left", 32'(bif.aref_busy), 32'h0);
        to_cyc(c0 + 700);
        chk("post_drain", 32'(exp_q.size()), 32'h0);
        bif.init_end = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("post_clear_req", 32'(bif.aref_req), 32'h0);

        // Saturation: ten ticks without a grant.
        c0 = cyc;
        bif.init_end = 1'b1;
        to_cyc(c0 + 9 * REFI - 1);
        chk("sat_ovf_before", 32'(bif.aref_overflow), 32'h0);
        to_cyc(c0 + 9 * REFI);
        chk("sat_ovf_9th", 32'(bif.aref_overflow), 32'h1);
        to_cyc(c0 + 10 * REFI);
        chk("sat_ovf_10th", 32'(bif.aref_overflow), 32'h1);
        bif.aref_en = 1'b1;
        for (int i = 0; i < 4; i++) push_seq(c0 + 10 * REFI + 1 + SEQ * i);
        to_cyc(c0 + 923);
        chk("sat_urgent_923", 32'(bif.aref_urgent), 32'h1);
        to_cyc(c0 + 924);
        chk("sat_urgent_924", 32'(bif.aref_urgent), 32'h0);
        bif.aref_en = 1'b0;
        to_cyc(c0 + 950);
        chk("sat_drain", 32'(exp_q.size()), 32'h0);
        bif.init_end = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("sat_ovf_init_low", 32'(bif.aref_overflow), 32'h1);
        chk("sat_req_init_low", 32'(bif.aref_req), 32'h0);
        bif.init_end = 1'b1;
        repeat (3) @(negedge clk);
        chk("sat_ovf_init_high", 32'(bif.aref_overflow), 32'h1);
        bif.init_end = 1'b0;
        repeat (3) @(negedge clk);

        // Tick aligned with completion: pending must stay at one.
        c0 = cyc;
        bif.init_end = 1'b1;
        push_seq(c0 + 130);
        push_seq(c0 + 171);
        to_cyc(c0 + 129);
        chk("sim_req", 32'(bif.aref_req), 32'h1);
        bif.aref_en = 1'b1;
        to_cyc(c0 + 130);
        bif.aref_en = 1'b0;
        to_cyc(c0 + 160);
        chk("sim_end_pulse", 32'(bif.aref_end), 32'h1);
        chk("sim_req_kept", 32'(bif.aref_req), 32'h1);
        to_cyc(c0 + 170);
        bif.aref_en = 1'b1;
        to_cyc(c0 + 210);
        chk("sim_req_empty", 32'(bif.aref_req), 32'h0);
        to_cyc(c0 + 230);
        bif.aref_en = 1'b0;
        to_cyc(c0 + 235);
        chk("sim_drain", 32'(exp_q.size()), 32'h0);
        bif.init_end = 1'b0;
        repeat (3) @(negedge clk);

        // Asynchronous reset in the middle of the tRFC wait.
        bif.aref_en = 1'b1;
        c0 = cyc;
        bif.init_end = 1'b1;
        push_ev(EvPre, c0 + REFI + 1);
        push_ev(EvAref, c0 + REFI + 1 + RP);
        to_cyc(c0 + 95);
        chk("arst_busy_before", 32'(bif.aref_busy), 32'h1);
        #1 rst = 1'b1;
        #1;
        chk("arst_busy", 32'(bif.aref_busy), 32'h0);
        chk("arst_cmd", 32'(bif.aref_cmd), 32'h7);
        chk("arst_ovf", 32'(bif.aref_overflow), 32'h0);
        chk("arst_req", 32'(bif.aref_req), 32'h0);
        chk("arst_end", 32'(bif.aref_end), 32'h0);
        chk("arst_addr", 32'(bif.aref_addr), 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        c0 = cyc;
        push_seq(c0 + REFI + 1);
        to_cyc(c0 + REFI - 1);
        chk("arst_req_before", 32'(bif.aref_req), 32'h0);
        to_cyc(c0 + REFI);
        chk("arst_req_tick", 32'(bif.aref_req), 32'h1);
        to_cyc(c0 + 120);
        chk("arst_drain", 32'(exp_q.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
